// File: rtl/capture_seq.sv
// capture_seq: run-control sequencer for the logic/DSO capture datapath.
// Takes host start/stop/zero/ack commands, latches and derives the capture
// configuration words, gates sample_en and issues the DSO zero-calibration pulse.
//
// Optional feature macro: CAPTURE_SEQ_TIMEOUT_EN (adds timeout_cyc input and a
// RUN-state watchdog; without it run_timeout is tied to 0).
//
// Ports:
//   core_clk, core_rst            clock, synchronous active-high reset
//   host_start/stop/zero/ack      one-cycle host commands
//   cfg_depth, cfg_trig_pos       requested depth / pre-trigger count (32b)
//   cfg_cons_mode                 DSO mode select
//   capture_done                  end-of-capture pulse from the datapath
//   dso_setZero_done              calibration-complete pulse
//   timeout_cyc                   watchdog limit, 0 = disabled (macro only)
//   sample_en                     capture enable
//   sample_depth .. after_trig_depth, cons_mode   latched configuration words
//   dso_setZero                   one-cycle calibration pulse
//   busy, run_done                status (busy in ZERO/ARM/RUN, run_done in DONE)
//   run_aborted, run_timeout      sticky end-of-run reasons
module capture_seq #(
    parameter int unsigned MIN_DEPTH = 2,
    parameter int unsigned ARM_CYC   = 4,
    parameter int unsigned TIMEOUT_W = 32
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        host_start,
    input  logic        host_stop,
    input  logic        host_zero,
    input  logic        host_ack,
    input  logic [31:0] cfg_depth,
    input  logic [31:0] cfg_trig_pos,
    input  logic        cfg_cons_mode,
    input  logic        capture_done,
    input  logic        dso_setZero_done,
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    input  logic [TIMEOUT_W-1:0] timeout_cyc,
`endif
    output logic        sample_en,
    output logic [31:0] sample_depth,
    output logic [31:0] sample_last_cnt,
    output logic [31:0] sample_real_start,
    output logic [31:0] trig_set_pos,
    output logic [31:0] trig_set_pos_minus1,
    output logic [31:0] after_trig_depth,
    output logic        cons_mode,
    output logic        dso_setZero,
    output logic        busy,
    output logic        run_done,
    output logic        run_aborted,
    output logic        run_timeout
);

    localparam int unsigned ARM_W = (ARM_CYC > 1) ? $clog2(ARM_CYC) : 1;

    // Parameter sanity: zero values would make the counters/derivations wrap.
    if (MIN_DEPTH == 0 || ARM_CYC == 0 || TIMEOUT_W == 0) begin : g_bad_param
        $error("capture_seq: MIN_DEPTH, ARM_CYC and TIMEOUT_W must be non-zero");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ZERO,
        S_ARM,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [ARM_W-1:0] r_arm_cnt;

    // Derived configuration, only sampled into registers on the latch cycle.
    logic [31:0] w_d;
    logic [31:0] w_d_m1;
    logic [31:0] w_p;
    logic        w_p_zero;
    logic        w_latch;
    logic        w_timeout_hit;

    assign w_d      = (cfg_depth < 32'(MIN_DEPTH)) ? 32'(MIN_DEPTH) : cfg_depth;
    assign w_d_m1   = w_d - 32'd1;
    assign w_p      = (cfg_trig_pos > w_d_m1) ? w_d_m1 : cfg_trig_pos;
    assign w_p_zero = (w_p == 32'd0);

    // A start in DONE together with ack is treated as a plain ack.
    assign w_latch = host_start &&
                     ((r_state == S_IDLE) || ((r_state == S_DONE) && !host_ack));

`ifdef CAPTURE_SEQ_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_run_cnt;
    assign w_timeout_hit = (timeout_cyc != '0) && (r_run_cnt == timeout_cyc);
`else
    assign w_timeout_hit = 1'b0;
    assign run_timeout   = 1'b0;
`endif

    // Configuration word registers.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            sample_depth        <= '0;
            sample_last_cnt     <= '0;
            sample_real_start   <= '0;
            trig_set_pos        <= '0;
            trig_set_pos_minus1 <= '0;
            after_trig_depth    <= '0;
            cons_mode           <= 1'b0;
        end else if (w_latch) begin
            sample_depth        <= w_d;
            sample_last_cnt     <= w_d_m1;
            sample_real_start   <= w_p_zero ? 32'd0 : (w_d - w_p);
            trig_set_pos        <= w_p;
            trig_set_pos_minus1 <= w_p_zero ? 32'd0 : (w_p - 32'd1);
            after_trig_depth    <= w_d_m1 - w_p;
            cons_mode           <= cfg_cons_mode;
        end
    end

    // Run-control FSM with registered status outputs.
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_state     <= S_IDLE;
            r_arm_cnt   <= '0;
            sample_en   <= 1'b0;
            dso_setZero <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            run_aborted <= 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
            r_run_cnt   <= '0;
            run_timeout <= 1'b0;
`endif
        end else begin
            dso_setZero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (host_start) begin
                        r_state     <= S_ARM;
                        r_arm_cnt   <= '0;
                        busy        <= 1'b1;
                        run_aborted <= 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                        run_timeout <= 1'b0;
`endif
                    end else if (host_zero && cfg_cons_mode) begin
                        r_state     <= S_ZERO;
                        dso_setZero <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                S_ZERO: begin
                    if (host_stop || dso_setZero_done) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                    end
                end
                S_ARM: begin
                    if (host_stop) begin
                        r_state     <= S_IDLE;
                        busy        <= 1'b0;
                        run_aborted <= 1'b1;
                    end else if (r_arm_cnt == ARM_W'(ARM_CYC - 1)) begin
                        r_state   <= S_RUN;
                        sample_en <= 1'b1;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                        r_run_cnt <= '0;
`endif
                    end else begin
                        r_arm_cnt <= r_arm_cnt + ARM_W'(1);
                    end
                end
                S_RUN: begin
                    if (capture_done || host_stop || w_timeout_hit) begin
                        r_state   <= S_DONE;
                        sample_en <= 1'b0;
                        busy      <= 1'b0;
                        run_done  <= 1'b1;
                        // capture_done wins over a same-cycle stop or timeout
                        run_aborted <= !capture_done;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                        run_timeout <= !capture_done && w_timeout_hit;
`endif
                    end
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                    else begin
                        r_run_cnt <= r_run_cnt + TIMEOUT_W'(1);
                    end
`endif
                end
                S_DONE: begin
                    if (host_ack) begin
                        r_state  <= S_IDLE;
                        run_done <= 1'b0;
                    end else if (host_start) begin
                        r_state     <= S_ARM;
                        r_arm_cnt   <= '0;
                        busy        <= 1'b1;
                        run_done    <= 1'b0;
                        run_aborted <= 1'b0;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
                        run_timeout <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    sample_en <= 1'b0;
                    busy      <= 1'b0;
                    run_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/capture_seq.md
Name: capture_seq

Overview:
- Run-control sequencer for the logic/DSO capture datapath.
- Accepts host start/stop/zero commands and register-level depth/trigger settings.
- Derives the capture configuration words, gates sample_en, and issues the DSO zero-calibration pulse.
- Tracks capture_done and reports run status. Sits between the host register file and the capture datapath in the core_clk domain.

Parameters:
- MIN_DEPTH, 2, minimum accepted sample depth; smaller cfg_depth is raised to this value.
- ARM_CYC, 4, core_clk cycles held in ARM after config latch before sample_en asserts (trigger pipeline flush).
- TIMEOUT_W, 32, width of the optional run watchdog counter.

Ports:
- core_clk  in  1  single clock
- core_rst  in  1  synchronous active-high reset
- host_start  in  1  one-cycle start request
- host_stop  in  1  one-cycle abort request
- host_zero  in  1  one-cycle DSO zero-calibration request
- host_ack  in  1  one-cycle acknowledge of a finished run
- cfg_depth  in  32  requested sample depth
- cfg_trig_pos  in  32  requested pre-trigger sample count
- cfg_cons_mode  in  1  DSO mode select
- capture_done  in  1  one-cycle end-of-capture pulse from the datapath
- dso_setZero_done  in  1  one-cycle calibration-complete pulse
- sample_en  out  1  capture enable
- sample_depth  out  32  latched depth
- sample_last_cnt  out  32  depth-1
- sample_real_start  out  32  start offset
- trig_set_pos  out  32  clamped trigger position
- trig_set_pos_minus1  out  32  trig_set_pos-1, floored at 0
- after_trig_depth  out  32  post-trigger count
- cons_mode  out  1  latched cfg_cons_mode
- dso_setZero  out  1  one-cycle calibration pulse
- busy  out  1  high in any state except IDLE and DONE
- run_done  out  1  high in DONE
- run_aborted  out  1  sticky; last run ended by stop or timeout
- run_timeout  out  1  sticky; last run ended by watchdog

Behaviour:
- States: IDLE, ZERO, ARM, RUN, DONE. All registers update on rising core_clk.
- core_rst, at any time including mid-run:
  - State returns to IDLE.
  - All outputs clear to 0.
  - sample_en and dso_setZero drop on the cycle after reset is sampled.

IDLE:
- host_start: latch config (below), go to ARM, arm counter = 0.
- else host_zero with cfg_cons_mode=1: pulse dso_setZero for exactly one cycle, go to ZERO.
- host_zero with cfg_cons_mode=0 is ignored.
- Simultaneous start and zero: start wins; zero is dropped.

ZERO:
- Wait for dso_setZero_done, then go to IDLE.
- host_stop: go to IDLE without waiting.
- host_start is ignored.

ARM:
- Count ARM_CYC cycles.
- On the cycle the count reaches ARM_CYC-1, the next state is RUN and sample_en=1 from the following cycle.
- host_stop: go to IDLE, set run_aborted. sample_en never asserts.

RUN:
- sample_en=1.
- capture_done: sample_en=0 next cycle, go to DONE.
- host_stop without capture_done: sample_en=0 next cycle, set run_aborted, go to DONE.
- Same-cycle capture_done and host_stop: done wins; run_aborted stays 0.
- Any host_start is ignored.

DONE:
- Configuration outputs hold their values so downstream readout stays valid.
- host_ack: go to IDLE.
- host_start without ack: acts as ack plus restart; clears run_aborted and run_timeout, latches new config, goes straight to ARM.

Config latch (one cycle, registered, unsigned 32-bit):
- D = max(cfg_depth, MIN_DEPTH).
- P = min(cfg_trig_pos, D-1).
- sample_depth = D.
- sample_last_cnt = D-1.
- trig_set_pos = P.
- trig_set_pos_minus1 = (P==0) ? 0 : P-1.
- after_trig_depth = D-1-P.
- sample_real_start = (P==0) ? 0 : D-P.
- cons_mode = cfg_cons_mode.
- run_aborted and run_timeout clear on latch.
- cfg_* changes outside the latch cycle have no effect on the outputs.

Spurious inputs:
- capture_done outside RUN is ignored.
- dso_setZero_done outside ZERO is ignored.

Optional Feature:
- Macro: CAPTURE_SEQ_TIMEOUT_EN.
- When defined:
  - Adds input timeout_cyc [TIMEOUT_W-1:0].
  - Counter clears on RUN entry and increments each RUN cycle.
  - When the counter equals timeout_cyc with timeout_cyc!=0 and no capture_done that cycle: behave as host_stop and also set run_timeout.
  - timeout_cyc=0 disables the watchdog.
- When undefined: no timeout_cyc port, no counter, run_timeout tied to 0.

Test Plan:
- Reset mid-RUN: assert core_rst one cycle during RUN -> next cycle state IDLE, sample_en=0, busy=0, all config outputs 0.
- Normal run: cfg_depth=1000, cfg_trig_pos=100, start.
  - Expected config: sample_last_cnt=999, trig_set_pos=100, trig_set_pos_minus1=99, after_trig_depth=899, sample_real_start=900.
  - sample_en rises 1+ARM_CYC cycles after latch.
  - capture_done -> sample_en=0 next cycle, run_done=1; host_ack -> IDLE.
- Clamping: cfg_depth=0, cfg_trig_pos=50 -> sample_depth=2, trig_set_pos=1, trig_set_pos_minus1=0, after_trig_depth=0, sample_real_start=1.
- Abort: host_stop in ARM -> IDLE with run_aborted=1 and sample_en never high. Same-cycle host_stop and capture_done in RUN -> DONE, run_aborted=0.
- Zero calibration:
  - cons_mode=1, host_zero -> dso_setZero high exactly 1 cycle, busy=1 until dso_setZero_done, host_start during ZERO ignored.
  - cons_mode=0, host_zero -> no pulse.
- Timeout (macro defined): timeout_cyc=20, no capture_done -> sample_en drops after 20 RUN cycles, run_timeout=1, run_aborted=1. timeout_cyc=0 -> run continues indefinitely.
